// File: rtl/object_state_drawer_if.sv
// rtl/object_state_drawer_if.sv - object record, scan pixel and draw result signals of object_state_drawer
interface object_state_drawer_if;
    logic              frame_start;
    logic [0:4][0:10]  object_state;
    logic [10:0]       pixelX;
    logic [10:0]       pixelY;
    logic              pixel_valid;
    logic              blink;
    logic              drawing_request;
    logic [10:0]       offsetX;
    logic [10:0]       offsetY;
    logic [10:0]       img_id;

    modport master (
        output frame_start, object_state, pixelX, pixelY, pixel_valid, blink,
        input  drawing_request, offsetX, offsetY, img_id
    );

    modport slave (
        input  frame_start, object_state, pixelX, pixelY, pixel_valid, blink,
        output drawing_request, offsetX, offsetY, img_id
    );
endinterface

// File: rtl/object_state_drawer.sv
// rtl/object_state_drawer.sv - per-frame object record latch and 2-stage pixel hit test (optional blink: OBJECT_DRAWER_BLINK_EN)
module object_state_drawer #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BLINK_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    object_state_drawer_if.slave bus
);
    localparam logic [11:0] SCREEN_W12 = 12'(SCREEN_W);
    localparam logic [11:0] SCREEN_H12 = 12'(SCREEN_H);

    logic        fs_d_q;
    logic [10:0] img_q, x_q, y_q, w_q, h_q;

    logic        hit_d, hit_q;
    logic [10:0] dx_d, dy_d, dx_q, dy_q;

    logic        draw_ok;
    logic        suppress;
    logic        dr_q;
    logic [10:0] ox_q, oy_q;

    // The producer updates object_state on the frame_start edge, so capture one cycle later.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fs_d_q <= 1'b0;
            img_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
        end else begin
            fs_d_q <= bus.frame_start;
            if (fs_d_q) begin
                img_q <= bus.object_state[0];
                x_q   <= bus.object_state[1];
                y_q   <= bus.object_state[2];
                w_q   <= bus.object_state[3];
                h_q   <= bus.object_state[4];
            end
        end
    end

    logic [11:0] px12, py12, x12, y12, x_end, y_end;

    // 12-bit sums keep an object hanging past the screen edge from wrapping to column/row 0.
    always_comb begin
        px12  = {1'b0, bus.pixelX};
        py12  = {1'b0, bus.pixelY};
        x12   = {1'b0, x_q};
        y12   = {1'b0, y_q};
        x_end = x12 + {1'b0, w_q};
        y_end = y12 + {1'b0, h_q};
        hit_d = bus.pixel_valid
              && (px12 >= x12) && (px12 < x_end)
              && (py12 >= y12) && (py12 < y_end)
              && (px12 < SCREEN_W12) && (py12 < SCREEN_H12);
        dx_d  = bus.pixelX - x_q;
        dy_d  = bus.pixelY - y_q;
    end

`ifdef OBJECT_DRAWER_BLINK_EN
    localparam int CNT_W = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_FRAMES);

    logic [CNT_W-1:0] blink_cnt_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_q <= '0;
        end else if (!bus.blink) begin
            blink_cnt_q <= '0;
        end else if (fs_d_q) begin
            blink_cnt_q <= (blink_cnt_q == CNT_LAST) ? '0 : blink_cnt_q + 1'b1;
        end
    end

    assign suppress = bus.blink && (blink_cnt_q >= CNT_HALF);
`else
    logic unused_blink;
    assign unused_blink = bus.blink & (BLINK_FRAMES > 0);
    assign suppress     = 1'b0;
`endif

    assign draw_ok = hit_q && !suppress;

    // Stage 1 holds the result of the record in force when the pixel arrived, so a capture never disturbs it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_q <= 1'b0;
            dx_q  <= '0;
            dy_q  <= '0;
            dr_q  <= 1'b0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else begin
            hit_q <= hit_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            dr_q  <= draw_ok;
            ox_q  <= draw_ok ? dx_q : 11'd0;
            oy_q  <= draw_ok ? dy_q : 11'd0;
        end
    end

    assign bus.drawing_request = dr_q;
    assign bus.offsetX         = ox_q;
    assign bus.offsetY         = oy_q;
    assign bus.img_id          = img_q;
endmodule

// File: doc/object_state_drawer.md
OBJECT_STATE_DRAWER -- requirements
Module: object_state_drawer

Interface
REQ-001 Parameter: SCREEN_W, 640, visible width in pixels; pixels with pixelX >= SCREEN_W are never drawn.
REQ-002 Parameter: SCREEN_H, 480, visible height in pixels; pixels with pixelY >= SCREEN_H are never drawn.
REQ-003 Parameter: BLINK_FRAMES, 8, frames per blink half-period (only used with OBJECT_DRAWER_BLINK_EN).
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse at the start of each frame, shared with the state producer.
REQ-007 object_state  input  [0:4][0:10]  record from the state producer: [0] img_id, [1] x, [2] y, [3] width, [4] height.
REQ-008 pixelX  input  11  current scan X coordinate.
REQ-009 pixelY  input  11  current scan Y coordinate.
REQ-010 pixel_valid  input  1  pixelX/pixelY are valid this cycle.
REQ-011 blink  input  1  request blinking (ignored without OBJECT_DRAWER_BLINK_EN).
REQ-012 drawing_request  output  1  pixel (2 cycles earlier) lies inside the object.
REQ-013 offsetX  output  11  pixelX minus object x; 0 when drawing_request is low.
REQ-014 offsetY  output  11  pixelY minus object y; 0 when drawing_request is low.
REQ-015 img_id  output  11  latched img_id; held for the whole frame.

Function
REQ-016 Latch timing: one-cycle-delayed copy of frame_start (fs_d); on the fs_d cycle the block captures object_state into the active record; this capture sees the value the producer registered on the frame_start edge.
REQ-017 The active record is constant between captures; object_state changes at any other time have no effect.
REQ-018 Hit test: x <= pixelX < x+width and y <= pixelY < y+height, sums computed 12 bits wide (no wrap); pixelX < SCREEN_W; pixelY < SCREEN_H; pixel_valid high.
REQ-019 width==0 or height==0: the object never draws.
REQ-020 x+width > SCREEN_W: the object is clipped at SCREEN_W without wrap to column 0; same rule vertically.
REQ-021 Pipeline: stage 1 registers the compare results and 11-bit differences; stage 2 registers the outputs; latency from pixel inputs to drawing_request/offsets is exactly 2 cycles, throughput one pixel per cycle.
REQ-022 If the capture happens while a pixel is in flight, that pixel completes using the record it was compared against in stage 1.
REQ-023 pixel_valid low: the corresponding output cycle has drawing_request=0, offsetX=offsetY=0.

Reset
REQ-024 Reset clears the active record, fs_d, and all pipeline registers.
REQ-025 Reset values: drawing_request=0, offsetX=0, offsetY=0, img_id=0.
REQ-026 Reset asserted mid-frame: outputs go to reset values immediately; after deassertion the object stays non-drawing (zero size) until the next fs_d capture.

Configuration
REQ-027 Macro OBJECT_DRAWER_BLINK_EN, when defined: a frame counter increments on each fs_d and wraps at 2*BLINK_FRAMES-1; while blink=1, drawing_request is forced to 0 during counts >= BLINK_FRAMES; the counter resets to 0 on resetN and whenever blink=0.
REQ-028 Without OBJECT_DRAWER_BLINK_EN: no counter exists, blink is ignored, and the output path is identical to blink=0.

Verification
REQ-029 Scenario: capture {0,256,380,32,36}; pixel (256,380) -> drawing_request=1, offsets (0,0) two cycles later; (287,415) -> 1, offsets (31,35); (288,380) -> 0.
REQ-030 Scenario: producer updates x 256->257 on the frame_start edge -> record holds 257 after fs_d; pixel (256,380) in that frame -> 0.
REQ-031 Scenario: record {5,620,10,40,10}; pixel (639,10) -> 1; pixel (0,10) and (4,10) -> 0 (no wrap); img_id=5.
REQ-032 Scenario: width=0, pixel equal to (x,y) -> drawing_request=0; pixel_valid=0 on an in-object pixel -> 0, offsets 0.
REQ-033 Scenario: resetN pulsed low mid-frame -> outputs 0 that cycle; nothing draws until the next frame_start+1 capture.
REQ-034 Scenario (BLINK_EN, BLINK_FRAMES=8, blink=1): an in-object pixel draws in frames 0-7, is suppressed in frames 8-15, and draws again in frame 16.
